// File: rtl/l2_scrubber_pkg.sv
// l2_scrubber_pkg
// Shared definitions for the L2 background ECC scrubber:
//   - scrub_state_e        : scrubber FSM states (IDLE/WAIT/ISSUE/RESP)
//   - L2Port1NonInterlBase : default scrub base (non-interleaved L2 alias)
//   - AxiLenSingle         : AR burst length for a single beat
//   - AxiBurstIncr         : AR burst type INCR
package l2_scrubber_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    RESP  = 2'd3
  } scrub_state_e;

  localparam logic [47:0] L2Port1NonInterlBase = 48'h0;

  localparam logic [7:0] AxiLenSingle = 8'd0;
  localparam logic [1:0] AxiBurstIncr = 2'b01;

endpackage

// File: rtl/l2_scrub_sat_cnt.sv
// l2_scrub_sat_cnt
// Saturating up-counter with enable; sticks at all-ones.
// Ports:
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset (clears the count)
//   i_en    : count one event this cycle
//   o_cnt   : current count
module l2_scrub_sat_cnt #(
  parameter int Width = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic [Width-1:0] o_cnt
);

  logic [Width-1:0] r_cnt;

  // Count events until all-ones, then hold so software never sees a wrap
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {Width{1'b1}})) begin
      r_cnt <= r_cnt + Width'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/l2_scrubber.sv
// l2_scrubber
// Background ECC scrubber: walks the L2 range with single-beat AXI reads
// (one outstanding) so the L2 ECC logic corrects latent errors, counts ECC
// error pulses and error responses, and records the address being scrubbed
// when an error shows up.
// Ports:
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   enable_i, interval_i     : scrub enable, idle cycles between reads
//   ecc_error_i              : ECC error pulse from the L2 memory wrapper
//   ar_*                     : AXI read-address channel (master side)
//   r_*                      : AXI read-data channel (master side)
//   busy_o                   : FSM not idle
//   sweep_done_o             : one-cycle pulse when the walk wraps
//   ecc_err_cnt_o            : saturating count of ECC error cycles
//   resp_err_cnt_o           : saturating count of SLVERR/DECERR responses
//   last_err_addr_o          : address of the most recent erroneous scrub
module l2_scrubber
  import l2_scrubber_pkg::*;
#(
  parameter int                    AxiAddrWidth  = 48,
  parameter int                    AxiDataWidth  = 64,
  parameter int                    AxiIdWidth    = 5,
  parameter logic [AxiIdWidth-1:0] ScrubId       = '0,
  parameter logic [AxiAddrWidth-1:0] BaseAddr    = AxiAddrWidth'(L2Port1NonInterlBase),
  parameter int unsigned           L2MemSize     = 2**20,
  parameter int                    IntervalWidth = 16,
  parameter int                    CntWidth      = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic [IntervalWidth-1:0] interval_i,
  input  logic                     ecc_error_i,
  output logic                     ar_valid_o,
  input  logic                     ar_ready_i,
  output logic [AxiAddrWidth-1:0]  ar_addr_o,
  output logic [AxiIdWidth-1:0]    ar_id_o,
  output logic [7:0]               ar_len_o,
  output logic [2:0]               ar_size_o,
  output logic [1:0]               ar_burst_o,
  input  logic                     r_valid_i,
  output logic                     r_ready_o,
  input  logic [AxiIdWidth-1:0]    r_id_i,
  input  logic [1:0]               r_resp_i,
  input  logic                     r_last_i,
  output logic                     busy_o,
  output logic                     sweep_done_o,
  output logic [CntWidth-1:0]      ecc_err_cnt_o,
  output logic [CntWidth-1:0]      resp_err_cnt_o,
  output logic [AxiAddrWidth-1:0]  last_err_addr_o
);

  localparam int unsigned BeatBytes = AxiDataWidth / 8;
  localparam int          OffW      = $clog2(L2MemSize);
  localparam logic [OffW-1:0] LastOff = OffW'(L2MemSize - BeatBytes);
  localparam logic [OffW-1:0] Step    = OffW'(BeatBytes);

  scrub_state_e              r_state, w_state_next;
  logic [IntervalWidth-1:0]  r_cnt, w_cnt_next;
  logic [OffW-1:0]           r_offset;
  logic                      r_sweep_done;
  logic                      r_post_hs;
  logic [AxiAddrWidth-1:0]   r_prev_addr;
  logic [AxiAddrWidth-1:0]   r_last_err_addr;
  logic [AxiAddrWidth-1:0]   w_cur_addr;
  logic                      w_r_hs;
  logic                      w_resp_err;
  logic                      w_ecc_in_resp;
  logic                      w_ecc_post_hs;
  logic                      w_unused_axi;

  assign w_cur_addr    = BaseAddr + AxiAddrWidth'(r_offset);
  assign w_r_hs        = (r_state == RESP) && r_valid_i;
  assign w_resp_err    = w_r_hs && r_resp_i[1];
  assign w_ecc_in_resp = ecc_error_i && (r_state == RESP);
  assign w_ecc_post_hs = ecc_error_i && r_post_hs;

  // R ID/last carry no information for single-beat fixed-ID reads, and
  // resp[0] only separates OKAY from EXOKAY
  assign w_unused_axi = ^{r_id_i, r_last_i, r_resp_i[0]};

  // Next-state and handshake outputs. ISSUE ignores enable_i so that a
  // raised ar_valid is never withdrawn before the slave accepts it.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    ar_valid_o   = 1'b0;
    r_ready_o    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable_i) begin
          w_state_next = WAIT;
          w_cnt_next   = interval_i;
        end
      end
      WAIT: begin
        if (!enable_i) begin
          w_state_next = IDLE;
        end else if (r_cnt == '0) begin
          w_state_next = ISSUE;
        end else begin
          w_cnt_next = r_cnt - IntervalWidth'(1);
        end
      end
      ISSUE: begin
        ar_valid_o = 1'b1;
        if (ar_ready_i) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        r_ready_o = 1'b1;
        if (r_valid_i) begin
          if (enable_i) begin
            w_state_next = WAIT;
            w_cnt_next   = interval_i;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FSM state and inter-read interval counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Address walk. The address of the read just completed is kept for one
  // cycle so an ECC pulse arriving right after the R beat is attributed to it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_offset     <= '0;
      r_sweep_done <= 1'b0;
      r_post_hs    <= 1'b0;
      r_prev_addr  <= BaseAddr;
    end else begin
      r_sweep_done <= w_r_hs && (r_offset == LastOff);
      r_post_hs    <= w_r_hs;
      if (w_r_hs) begin
        r_prev_addr <= w_cur_addr;
        r_offset    <= (r_offset == LastOff) ? '0 : r_offset + Step;
      end
    end
  end

  // Error address capture: during RESP the live address is the one being
  // read; one cycle later the offset has moved on, so use the saved copy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_last_err_addr <= BaseAddr;
    end else if (w_resp_err || w_ecc_in_resp) begin
      r_last_err_addr <= w_cur_addr;
    end else if (w_ecc_post_hs) begin
      r_last_err_addr <= r_prev_addr;
    end
  end

  l2_scrub_sat_cnt #(.Width(CntWidth)) u_ecc_cnt (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_en    (ecc_error_i),
    .o_cnt   (ecc_err_cnt_o)
  );

  l2_scrub_sat_cnt #(.Width(CntWidth)) u_resp_cnt (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_en    (w_resp_err),
    .o_cnt   (resp_err_cnt_o)
  );

  assign ar_addr_o       = w_cur_addr;
  assign ar_id_o         = ScrubId;
  assign ar_len_o        = AxiLenSingle;
  assign ar_size_o       = 3'($clog2(BeatBytes));
  assign ar_burst_o      = AxiBurstIncr;
  assign busy_o          = (r_state != IDLE);
  assign sweep_done_o    = r_sweep_done;
  assign last_err_addr_o = r_last_err_addr;

endmodule

// File: tb/tb_l2_scrubber.sv
// tb_l2_scrubber
// Self-checking bench for l2_scrubber: an AXI read slave with randomized
// ready/valid delays and responses, checked against a reference model of
// the address walk, interval timing and error bookkeeping.
module tb_l2_scrubber;

  localparam int AW      = 48;
  localparam int IDW     = 5;
  localparam int CW      = 2;
  localparam int MemSize = 64;
  localparam int Beat    = 8;
  localparam logic [AW-1:0] Base = 48'h7800_0000;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic           enable_i;
  logic [15:0]    interval_i;
  logic           ecc_error_i;
  logic           ar_valid_o;
  logic           ar_ready_i;
  logic [AW-1:0]  ar_addr_o;
  logic [IDW-1:0] ar_id_o;
  logic [7:0]     ar_len_o;
  logic [2:0]     ar_size_o;
  logic [1:0]     ar_burst_o;
  logic           r_valid_i;
  logic           r_ready_o;
  logic [IDW-1:0] r_id_i;
  logic [1:0]     r_resp_i;
  logic           r_last_i;
  logic           busy_o;
  logic           sweep_done_o;
  logic [CW-1:0]  ecc_err_cnt_o;
  logic [CW-1:0]  resp_err_cnt_o;
  logic [AW-1:0]  last_err_addr_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            readIdx;
  int            eccCnt;
  int            respCnt;
  logic [AW-1:0] expLastErr;
  int            expGap;
  int            cycSinceHs = 0;

  l2_scrubber #(
    .AxiAddrWidth  (AW),
    .AxiDataWidth  (64),
    .AxiIdWidth    (IDW),
    .ScrubId       ('0),
    .BaseAddr      (Base),
    .L2MemSize     (MemSize),
    .IntervalWidth (16),
    .CntWidth      (CW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .enable_i        (enable_i),
    .interval_i      (interval_i),
    .ecc_error_i     (ecc_error_i),
    .ar_valid_o      (ar_valid_o),
    .ar_ready_i      (ar_ready_i),
    .ar_addr_o       (ar_addr_o),
    .ar_id_o         (ar_id_o),
    .ar_len_o        (ar_len_o),
    .ar_size_o       (ar_size_o),
    .ar_burst_o      (ar_burst_o),
    .r_valid_i       (r_valid_i),
    .r_ready_o       (r_ready_o),
    .r_id_i          (r_id_i),
    .r_resp_i        (r_resp_i),
    .r_last_i        (r_last_i),
    .busy_o          (busy_o),
    .sweep_done_o    (sweep_done_o),
    .ecc_err_cnt_o   (ecc_err_cnt_o),
    .resp_err_cnt_o  (resp_err_cnt_o),
    .last_err_addr_o (last_err_addr_o)
  );

  always #5 clk = ~clk;

  // Cycles elapsed since the most recent R handshake, for interval timing
  always @(posedge clk) begin
    if (r_valid_i && r_ready_o) cycSinceHs <= 0;
    else                        cycSinceHs <= cycSinceHs + 1;
  end

  // Global time limit so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [AW-1:0] addrOf(input int idx);
    return Base + AW'((idx * Beat) % MemSize);
  endfunction

  function automatic int satInc(input int v);
    return (v >= (1 << CW) - 1) ? v : v + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkModel();
    checkOutput("ecc_err_cnt", 64'(ecc_err_cnt_o), 64'(eccCnt));
    checkOutput("resp_err_cnt", 64'(resp_err_cnt_o), 64'(respCnt));
    checkOutput("last_err_addr", 64'(last_err_addr_o), 64'(expLastErr));
  endtask

  task automatic waitArValid();
    for (int i = 0; i < 100 && ar_valid_o !== 1'b1; i++) @(negedge clk);
    if (ar_valid_o !== 1'b1) begin
      checkOutput("ar_valid_timeout", 64'(ar_valid_o), 64'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] no read issued");
    end
  endtask

  // One complete scrub read as seen by the slave, with the model updated
  // at the R handshake. Inputs change only on the falling edge.
  task automatic applyStimulus(input int arDelay, input int rDelay, input logic [1:0] resp,
                               input bit eccResp, input bit eccAfter,
                               input int nextInterval, input int dropAt);
    logic [AW-1:0] expAddr;
    bit            expSweep;
    expAddr  = addrOf(readIdx);
    expSweep = ((readIdx % (MemSize / Beat)) == (MemSize / Beat) - 1);
    waitArValid();
    if (expGap >= 0) checkOutput("read_gap", 64'(cycSinceHs), 64'(expGap));
    checkOutput("ar_addr", 64'(ar_addr_o), 64'(expAddr));
    checkOutput("sweep_idle", 64'(sweep_done_o), 64'd0);
    for (int i = 0; i < arDelay; i++) begin
      if (i == dropAt) enable_i = 1'b0;
      @(negedge clk);
      checkOutput("ar_valid_hold", 64'(ar_valid_o), 64'd1);
      checkOutput("ar_addr_hold", 64'(ar_addr_o), 64'(expAddr));
    end
    ar_ready_i = 1'b1;
    @(negedge clk);
    ar_ready_i = 1'b0;
    checkOutput("r_ready", 64'(r_ready_o), 64'd1);
    checkOutput("ar_valid_drop", 64'(ar_valid_o), 64'd0);
    if (eccResp) begin
      ecc_error_i = 1'b1;
      eccCnt      = satInc(eccCnt);
      expLastErr  = expAddr;
    end
    for (int i = 0; i < rDelay; i++) begin
      @(negedge clk);
      ecc_error_i = 1'b0;
    end
    interval_i = 16'(nextInterval);
    r_valid_i  = 1'b1;
    r_resp_i   = resp;
    @(negedge clk);
    r_valid_i   = 1'b0;
    r_resp_i    = 2'b00;
    ecc_error_i = 1'b0;
    if (resp[1]) begin
      respCnt    = satInc(respCnt);
      expLastErr = expAddr;
    end
    readIdx++;
    checkOutput("sweep_done", 64'(sweep_done_o), 64'(expSweep));
    checkOutput("busy_after_r", 64'(busy_o), 64'(enable_i));
    checkModel();
    if (eccAfter) begin
      ecc_error_i = 1'b1;
      @(negedge clk);
      ecc_error_i = 1'b0;
      eccCnt      = satInc(eccCnt);
      expLastErr  = expAddr;
      checkModel();
    end
    expGap = enable_i ? nextInterval + 1 : -1;
  endtask

  task automatic resetModel();
    readIdx    = 0;
    eccCnt     = 0;
    respCnt    = 0;
    expLastErr = Base;
    expGap     = -1;
  endtask

  initial begin
    rst_ni      = 1'b0;
    enable_i    = 1'b0;
    interval_i  = 16'd0;
    ecc_error_i = 1'b0;
    ar_ready_i  = 1'b0;
    r_valid_i   = 1'b0;
    r_id_i      = '0;
    r_resp_i    = 2'b00;
    r_last_i    = 1'b1;
    resetModel();

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_ar_valid", 64'(ar_valid_o), 64'd0);
    checkOutput("rst_r_ready", 64'(r_ready_o), 64'd0);
    checkOutput("rst_busy", 64'(busy_o), 64'd0);
    checkOutput("rst_sweep", 64'(sweep_done_o), 64'd0);
    checkOutput("rst_ar_addr", 64'(ar_addr_o), 64'(Base));
    checkModel();
    rst_ni = 1'b1;
    @(negedge clk);
    checkOutput("ar_size", 64'(ar_size_o), 64'd3);
    checkOutput("ar_len", 64'(ar_len_o), 64'd0);
    checkOutput("ar_burst", 64'(ar_burst_o), 64'd1);
    checkOutput("ar_id", 64'(ar_id_o), 64'd0);

    // Full sweep plus wrap, back-to-back reads
    enable_i = 1'b1;
    for (int n = 0; n < 9; n++) applyStimulus(0, 0, 2'b00, 0, 0, (n == 8) ? 5 : 0, -1);

    // Interval of 5 idle cycles
    applyStimulus(0, 0, 2'b00, 0, 0, 5, -1);
    applyStimulus(0, 1, 2'b00, 0, 0, 0, -1);

    // Slave stalls AR while enable drops: request stays up, then FSM idles
    applyStimulus(10, 0, 2'b00, 0, 0, 0, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("idle_busy", 64'(busy_o), 64'd0);
      checkOutput("idle_ar_valid", 64'(ar_valid_o), 64'd0);
    end

    // Randomized traffic
    enable_i = 1'b1;
    for (int n = 0; n < 24; n++) begin
      logic [1:0] resp;
      resp = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) resp[1] = 1'b0;
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 3), resp,
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                    $urandom_range(0, 4), -1);
    end

    // Reset while a read is outstanding
    waitArValid();
    ar_ready_i = 1'b1;
    @(negedge clk);
    ar_ready_i = 1'b0;
    rst_ni     = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    resetModel();
    checkOutput("rresp_busy", 64'(busy_o), 64'd0);
    checkOutput("rresp_ar_valid", 64'(ar_valid_o), 64'd0);
    checkOutput("rresp_r_ready", 64'(r_ready_o), 64'd0);
    checkOutput("rresp_ar_addr", 64'(ar_addr_o), 64'(Base));
    checkModel();

    // Errors on the read at offset 0x10, then an ECC pulse during WAIT
    applyStimulus(0, 0, 2'b00, 0, 0, 0, -1);
    applyStimulus(0, 0, 2'b00, 0, 0, 0, -1);
    applyStimulus(0, 0, 2'b10, 0, 1, 6, -1);
    checkOutput("err_addr_0x10", 64'(last_err_addr_o), 64'h7800_0010);
    repeat (3) @(negedge clk);
    ecc_error_i = 1'b1;
    @(negedge clk);
    ecc_error_i = 1'b0;
    eccCnt      = satInc(eccCnt);
    checkOutput("wait_busy", 64'(busy_o), 64'd1);
    checkModel();

    // Response counter saturation
    for (int n = 0; n < 5; n++) applyStimulus(0, 0, 2'b10, 0, 0, 0, -1);
    checkOutput("resp_sat", 64'(resp_err_cnt_o), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_scrubber.md
Name: l2_scrubber

Overview:
- Background ECC scrubber that drives one L2 slave port as an AXI read-only master, upstream of that port's CDC source.
- Walks the whole L2 range with single-beat reads so the L2 ECC logic detects and corrects latent bit errors.
- Counts ECC error pulses from the L2 memory wrapper and records the address being scrubbed when one occurs.
- One outstanding read at a time; throttled by a programmable inter-read interval.

Parameters:
- AxiAddrWidth, 48, AR address width
- AxiDataWidth, 64, R data width; BeatBytes = AxiDataWidth/8 (localparam)
- AxiIdWidth, 5, AR/R ID width
- ScrubId, 0, fixed ARID used for every scrub read
- BaseAddr, 48'h0, first scrubbed byte address (non-interleaved L2 alias)
- L2MemSize, 2**20, bytes scrubbed; must be a multiple of BeatBytes
- IntervalWidth, 16, width of interval_i
- CntWidth, 16, width of the error counters

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- enable_i  in  1  scrubbing enabled
- interval_i  in  IntervalWidth  idle cycles between reads
- ecc_error_i  in  1  ECC error pulse from the L2 memory wrapper
- ar_valid_o  out  1  AR valid
- ar_ready_i  in  1  AR ready
- ar_addr_o  out  AxiAddrWidth  read address
- ar_id_o  out  AxiIdWidth  read ID, always ScrubId
- ar_len_o  out  8  burst length, always 0
- ar_size_o  out  3  beat size, always log2(BeatBytes)
- ar_burst_o  out  2  burst type, always INCR
- r_valid_i  in  1  R valid
- r_ready_o  out  1  R ready
- r_id_i  in  AxiIdWidth  R ID (ignored)
- r_resp_i  in  2  R response
- r_last_i  in  1  R last (ignored, single beat)
- busy_o  out  1  FSM not in IDLE
- sweep_done_o  out  1  one-cycle pulse when the address wraps
- ecc_err_cnt_o  out  CntWidth  saturating count of ecc_error_i cycles
- resp_err_cnt_o  out  CntWidth  saturating count of SLVERR/DECERR responses
- last_err_addr_o  out  AxiAddrWidth  address of the most recent erroneous scrub

Behaviour:
- Reset (sync, rst_ni=0 at the clock edge):
  - State IDLE; offset=0; interval counter=0.
  - Both error counters=0; last_err_addr_o=BaseAddr.
  - ar_valid_o=0, r_ready_o=0, busy_o=0, sweep_done_o=0.
  - Reset mid-transaction abandons the outstanding read; the interconnect is reset together with this block.
- Address: ar_addr_o = BaseAddr + offset.
  - offset is a log2(L2MemSize)-bit register that advances by BeatBytes after each R handshake.
  - When offset == L2MemSize-BeatBytes, the advance wraps offset to 0 and sweep_done_o=1 in the following cycle.
- FSM states IDLE, WAIT, ISSUE, RESP:
  - IDLE: when enable_i=1, go to WAIT and load the counter with interval_i.
  - WAIT:
    - enable_i=0 -> IDLE.
    - Otherwise, counter==0 -> ISSUE; else decrement the counter.
    - interval_i=0 therefore gives 1 WAIT cycle.
  - ISSUE:
    - ar_valid_o=1 with the address stable.
    - ar_valid_o is never withdrawn before ar_ready_i, even if enable_i drops.
    - On handshake -> RESP.
  - RESP:
    - r_ready_o=1.
    - On r_valid_i: advance offset, check r_resp_i, then go to WAIT (counter reloaded) if enable_i=1, else IDLE.
- Best-case loop with interval_i=0 and immediate ready/valid: one read every 3 cycles (WAIT, ISSUE, RESP).
- Errors:
  - ecc_error_i=1 in any cycle: ecc_err_cnt_o increments, saturating at all-ones.
  - If that cycle is in RESP, or is the first cycle after an R handshake, last_err_addr_o captures the read's address.
  - r_resp_i[1]=1 on an R handshake: resp_err_cnt_o increments (saturating) and last_err_addr_o captures the read's address.
  - If a response error and an ECC-error capture fall in the same cycle, both counters update; last_err_addr_o gets the address once.
- interval_i and enable_i are sampled live; changing them during WAIT takes effect on the next reload.

Decomposition:
- carfield_pkg holds:
  - scrubber state enum (IDLE/WAIT/ISSUE/RESP).
  - Default scrub base constant = L2Port1NonInterlBase.
- AR constants (len 0, INCR) come from axi_pkg.
- One natural sub-module: l2_scrub_sat_cnt, a saturating counter with enable, instantiated twice.
- The FSM, address register and capture logic stay inline.

Test Plan:
- BaseAddr=0x7800_0000, L2MemSize=64, BeatBytes=8, interval_i=0, always-ready slave -> ARADDR 0x78000000,0x78000008,…,0x78000038,0x78000000; sweep_done_o pulses once after 8th R; reads 3 cycles apart.
- interval_i=5 -> ar_valid_o rises exactly 6 cycles after each R handshake (WAIT cycles counting 5..0).
- Slave holds ar_ready_i=0 for 10 cycles while enable_i drops in cycle 2 -> ar_valid_o and address held stable throughout; after the R handshake, state IDLE and busy_o=0.
- ecc_error_i pulsed 1 cycle after R for 0x78000010 -> ecc_err_cnt_o=1, last_err_addr_o=0x78000010; a pulse in WAIT 4 cycles later -> count 2, address unchanged.
- r_resp_i=SLVERR on read 3 -> resp_err_cnt_o=1, last_err_addr_o=0x78000010; CntWidth=2 with 5 errors -> counter saturates at 3.
- rst_ni=0 for one edge while in RESP -> next cycle: IDLE, offset 0, counters 0, ar_valid_o=0, r_ready_o=0.
